// File: rtl/ntt_pkg.sv
// Shared types and constants for the NTT sequencer: FSM states, algorithm codes,
// layer counts and default memory/butterfly latencies.
package ntt_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_t;

  localparam logic ALGO_KYBER     = 1'b0;
  localparam logic ALGO_DILITHIUM = 1'b1;

  localparam int unsigned N = 256;

  localparam int unsigned LAYERS_KYBER     = 7;
  localparam int unsigned LAYERS_DILITHIUM = 8;

  localparam int unsigned RAM_LAT = 1;
  localparam int unsigned BFU_LAT = 4;

  function automatic logic [2:0] last_layer(input logic algo);
    return (algo == ALGO_DILITHIUM) ? 3'(LAYERS_DILITHIUM - 1) : 3'(LAYERS_KYBER - 1);
  endfunction

endpackage

// File: rtl/ntt_addr_gen.sv
// Combinational butterfly address pair (j, j+len) and twiddle ROM index
// for issue slot i of layer l, forward or inverse, Kyber or Dilithium.
module ntt_addr_gen (
  input  logic [6:0] i,
  input  logic [2:0] l,
  input  logic       intt,
  input  logic       algo,
  output logic [7:0] addr_a,
  output logic [7:0] addr_b,
  output logic [7:0] tw_idx
);
  import ntt_pkg::*;

  logic [3:0] s;
  logic [7:0] len;
  logic [7:0] mask;
  logic [7:0] i8;
  logic [7:0] blk;
  logic [8:0] inv_base;

  always_comb begin
    s        = '0;
    len      = '0;
    mask     = '0;
    i8       = {1'b0, i};
    blk      = '0;
    inv_base = '0;
    addr_a   = '0;
    addr_b   = '0;
    tw_idx   = '0;

    // Kyber INTT starts at len=2, hence the extra shift.
    if (intt) s = (algo == ALGO_DILITHIUM) ? {1'b0, l} : ({1'b0, l} + 4'd1);
    else      s = 4'd7 - {1'b0, l};

    len    = 8'd1 << s;
    mask   = len - 8'd1;
    addr_a = ((i8 & ~mask) << 1) | (i8 & mask);
    addr_b = addr_a + len;
    blk    = i8 >> s;

    if (!intt) begin
      tw_idx = (8'd1 << l) + blk;
    end else begin
      inv_base = ((algo == ALGO_DILITHIUM) ? 9'd256 : 9'd128) >> l;
      tw_idx   = 8'(inv_base - 9'd1 - {1'b0, blk});
    end
  end

endmodule

// File: rtl/ntt_ctrl.sv
// Forward/inverse NTT sequencer: issues 128 butterfly pairs per layer, delays
// write-back by RAM_LAT+BFU_LAT, drains between layers. NTT_CTRL_PERF_CNT_EN adds o_cycles.
module ntt_ctrl #(
  parameter int unsigned RAM_LAT = ntt_pkg::RAM_LAT,
  parameter int unsigned BFU_LAT = ntt_pkg::BFU_LAT
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic        i_intt,
  input  logic        i_algo,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_rd_en,
  output logic [7:0]  o_rd_addr_a,
  output logic [7:0]  o_rd_addr_b,
  output logic [7:0]  o_tw_idx,
  output logic        o_wr_en,
  output logic [7:0]  o_wr_addr_a,
  output logic [7:0]  o_wr_addr_b,
  output logic        o_bfu_intt,
  output logic        o_bfu_algo
`ifdef NTT_CTRL_PERF_CNT_EN
  , output logic [15:0] o_cycles
`endif
);
  import ntt_pkg::*;

  localparam int unsigned DLY = RAM_LAT + BFU_LAT;

  state_t     state_q, state_d;
  logic [6:0] i_q;
  logic [2:0] l_q;
  logic       intt_q, algo_q;
  logic       issue, accept, pipe_busy;
  logic [7:0] ga, gb, gtw;

  logic [DLY-1:0] wv_q;
  logic [7:0]     wa_q [DLY];
  logic [7:0]     wb_q [DLY];

  ntt_addr_gen u_addr_gen (
    .i      (i_q),
    .l      (l_q),
    .intt   (intt_q),
    .algo   (algo_q),
    .addr_a (ga),
    .addr_b (gb),
    .tw_idx (gtw)
  );

  assign issue  = (state_q == ISSUE);
  assign accept = (state_q == IDLE) && i_start;
  // The entry in the last stage is written this cycle, so only earlier stages block.
  assign pipe_busy = |wv_q[DLY-2:0];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    o_busy      = (state_q != IDLE);
    o_done      = (state_q == DONE);
    o_rd_en     = issue;
    o_rd_addr_a = issue ? ga  : '0;
    o_rd_addr_b = issue ? gb  : '0;
    o_tw_idx    = issue ? gtw : '0;
    unique case (state_q)
      IDLE:    if (i_start) state_d = ISSUE;
      ISSUE:   if (i_q == 7'd127) state_d = DRAIN;
      DRAIN:   if (!pipe_busy) state_d = (l_q == last_layer(algo_q)) ? DONE : ISSUE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      i_q    <= '0;
      l_q    <= '0;
      intt_q <= 1'b0;
      algo_q <= 1'b0;
    end else begin
      if (accept) begin
        i_q    <= '0;
        l_q    <= '0;
        intt_q <= i_intt;
        algo_q <= i_algo;
      end
      if (issue) i_q <= i_q + 7'd1;
      if (state_q == DRAIN && !pipe_busy) l_q <= l_q + 3'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wv_q <= '0;
      for (int unsigned k = 0; k < DLY; k++) begin
        wa_q[k] <= '0;
        wb_q[k] <= '0;
      end
    end else begin
      wv_q    <= {wv_q[DLY-2:0], issue};
      wa_q[0] <= ga;
      wb_q[0] <= gb;
      for (int unsigned k = 1; k < DLY; k++) begin
        wa_q[k] <= wa_q[k-1];
        wb_q[k] <= wb_q[k-1];
      end
    end
  end

  assign o_wr_en     = wv_q[DLY-1];
  assign o_wr_addr_a = wv_q[DLY-1] ? wa_q[DLY-1] : '0;
  assign o_wr_addr_b = wv_q[DLY-1] ? wb_q[DLY-1] : '0;
  assign o_bfu_intt  = intt_q;
  assign o_bfu_algo  = algo_q;

`ifdef NTT_CTRL_PERF_CNT_EN
  logic [15:0] cyc_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n)              cyc_q <= '0;
    else if (accept)           cyc_q <= '0;
    else if (state_q != IDLE)  cyc_q <= cyc_q + 16'd1;
  end

  assign o_cycles = cyc_q;
`endif

endmodule

// File: tb/tb_ntt_ctrl.sv
// Directed bench for ntt_ctrl: expected read/write schedule built from the
// textbook nested NTT loops, plus hand-computed spot values.
module tb_ntt_ctrl;

  logic       clk = 1'b0;
  logic       i_rst_n, i_start, i_intt, i_algo;
  logic       o_busy, o_done, o_rd_en, o_wr_en, o_bfu_intt, o_bfu_algo;
  logic [7:0] o_rd_addr_a, o_rd_addr_b, o_tw_idx, o_wr_addr_a, o_wr_addr_b;
`ifdef NTT_CTRL_PERF_CNT_EN
  logic [15:0] o_cycles;
`endif

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  int unsigned ma [1024];
  int unsigned mb [1024];
  int unsigned mt [1024];

  ntt_ctrl #(.RAM_LAT(1), .BFU_LAT(4)) dut (
    .i_clk       (clk),
    .i_rst_n     (i_rst_n),
    .i_start     (i_start),
    .i_intt      (i_intt),
    .i_algo      (i_algo),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_rd_en     (o_rd_en),
    .o_rd_addr_a (o_rd_addr_a),
    .o_rd_addr_b (o_rd_addr_b),
    .o_tw_idx    (o_tw_idx),
    .o_wr_en     (o_wr_en),
    .o_wr_addr_a (o_wr_addr_a),
    .o_wr_addr_b (o_wr_addr_b),
    .o_bfu_intt  (o_bfu_intt),
    .o_bfu_algo  (o_bfu_algo)
`ifdef NTT_CTRL_PERF_CNT_EN
    , .o_cycles  (o_cycles)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0d, expected %0d", tag, $time, got, exp);
    end
  endtask

  // Classic in-place NTT loop nest; pair order and twiddle counter k per block.
  task automatic build_model(input logic algo, input logic intt);
    int unsigned p, k, lmin;
    p    = 0;
    lmin = algo ? 1 : 2;
    if (!intt) begin
      k = 0;
      for (int unsigned len = 128; len >= lmin; len = len >> 1)
        for (int unsigned st = 0; st < 256; st += 2 * len) begin
          k++;
          for (int unsigned j = st; j < st + len; j++) begin
            ma[p] = j; mb[p] = j + len; mt[p] = k; p++;
          end
        end
    end else begin
      k = algo ? 256 : 128;
      for (int unsigned len = lmin; len <= 128; len = len << 1)
        for (int unsigned st = 0; st < 256; st += 2 * len) begin
          k--;
          for (int unsigned j = st; j < st + len; j++) begin
            ma[p] = j; mb[p] = j + len; mt[p] = k; p++;
          end
        end
    end
  endtask

  task automatic run_op(input logic algo, input logic intt, input int rst_at);
    int   L, tdone, c_end, ndone, done_at, n, k, idx;
    logic cut, e_rd, e_wr;
    int unsigned ea, eb, et, wa, wb;
    L       = algo ? 8 : 7;
    tdone   = 133 * L + 1;
    c_end   = (rst_at > 0) ? rst_at + 12 : tdone + 3;
    ndone   = 0;
    done_at = 0;
    build_model(algo, intt);

    @(negedge clk);
    chk("idle_busy", o_busy, 0);
    i_start = 1'b1;
    i_algo  = algo;
    i_intt  = intt;

    for (int c = 1; c <= c_end; c++) begin
      @(negedge clk);
      i_start = (c == 10 || c == tdone) ? 1'b1 : 1'b0;
      if (c == 20) begin
        i_algo = ~algo;
        i_intt = ~intt;
      end
      if (rst_at > 0) i_rst_n = (c == rst_at) ? 1'b0 : 1'b1;

      cut  = (rst_at > 0) && (c > rst_at);
      e_rd = 1'b0; ea = 0; eb = 0; et = 0;
      e_wr = 1'b0; wa = 0; wb = 0;
      if (!cut) begin
        n = (c - 1) / 133; k = (c - 1) % 133;
        if (n < L && k < 128) begin
          idx = n * 128 + k; e_rd = 1'b1; ea = ma[idx]; eb = mb[idx]; et = mt[idx];
        end
        if (c >= 6) begin
          n = (c - 6) / 133; k = (c - 6) % 133;
          if (n < L && k < 128) begin
            idx = n * 128 + k; e_wr = 1'b1; wa = ma[idx]; wb = mb[idx];
          end
        end
      end

      chk("rd_en", o_rd_en, e_rd);
      chk("rd_a", o_rd_addr_a, ea);
      chk("rd_b", o_rd_addr_b, eb);
      chk("tw_idx", o_tw_idx, et);
      chk("wr_en", o_wr_en, e_wr);
      chk("wr_a", o_wr_addr_a, wa);
      chk("wr_b", o_wr_addr_b, wb);
      chk("busy", o_busy, !cut && c <= tdone);
      chk("done", o_done, !cut && c == tdone);
      chk("bfu_intt", o_bfu_intt, cut ? 1'b0 : intt);
      chk("bfu_algo", o_bfu_algo, cut ? 1'b0 : algo);

      if (algo && !intt && c == 1) begin
        chk("dil_l0_a", o_rd_addr_a, 0);
        chk("dil_l0_b", o_rd_addr_b, 128);
        chk("dil_l0_tw", o_tw_idx, 1);
      end
      if (algo && !intt && c == 937) begin
        chk("dil_l7_a", o_rd_addr_a, 10);
        chk("dil_l7_b", o_rd_addr_b, 11);
        chk("dil_l7_tw", o_tw_idx, 133);
      end
      if (!algo && intt && c == 1) begin
        chk("kyi_l0_a", o_rd_addr_a, 0);
        chk("kyi_l0_b", o_rd_addr_b, 2);
        chk("kyi_l0_tw", o_tw_idx, 127);
      end
      if (!algo && intt && c == 799) begin
        chk("kyi_l6_a", o_rd_addr_a, 0);
        chk("kyi_l6_b", o_rd_addr_b, 128);
        chk("kyi_l6_tw", o_tw_idx, 1);
      end

      if (o_done === 1'b1) begin
        ndone++;
        done_at = c;
      end
    end

    i_start = 1'b0;
    i_rst_n = 1'b1;
    chk("done_count", ndone, (rst_at > 0) ? 0 : 1);
    chk("done_cycle", done_at, (rst_at > 0) ? 0 : tdone);
`ifdef NTT_CTRL_PERF_CNT_EN
    chk("cycles", o_cycles, (rst_at > 0) ? 0 : tdone);
`endif
  endtask

  initial begin
    i_rst_n = 1'b0;
    i_start = 1'b0;
    i_intt  = 1'b0;
    i_algo  = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_rd_en", o_rd_en, 0);
    chk("rst_rd_b", o_rd_addr_b, 0);
    chk("rst_wr_en", o_wr_en, 0);
    chk("rst_bfu_intt", o_bfu_intt, 0);
`ifdef NTT_CTRL_PERF_CNT_EN
    chk("rst_cycles", o_cycles, 0);
`endif
    i_rst_n = 1'b1;

    run_op(1'b1, 1'b0, 0);    // Dilithium NTT with ignored start pulses
    run_op(1'b0, 1'b1, 0);    // Kyber INTT
    run_op(1'b1, 1'b1, 300);  // Dilithium INTT, reset mid-layer
    run_op(1'b0, 1'b0, 0);    // Kyber NTT right after reset

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
